phase_inc_scheduler: RTL and testbench
======================================

Name: phase_inc_scheduler

Overview:
- Per-sample slot sequencer for the shared phase-increment datapath.
- On each `sample_clk_en` it walks every operator slot in fixed order: bank 0 ops 0..17, then bank 1 ops 0..17.
- Each slot: issues a register-file read, then tags the result emerging from the phase-increment stage with its bank/op, so the phase accumulator store writes the correct slot.
- Sits between the register file, the phase-increment stage and the per-operator phase accumulators.

Parameters:
- NUM_BANKS, 2, number of register banks iterated.
- NUM_OPS, 18, operators per bank.
- RD_LATENCY, 1, cycles from `rd_en` to register fields valid at the phase-increment inputs (range 0..4).
- PIPE_LATENCY, 1, registered stages inside the phase-increment stage (range 0..4).

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset; one clock domain `clk`, all state sampled on its rising edge
- sample_clk_en  in  1  single-cycle frame start strobe
- rd_en  out  1  register-file read request for slot {rd_bank, rd_op}
- rd_bank  out  BANK_NUM_WIDTH  bank of slot being read
- rd_op  out  OP_NUM_WIDTH  operator of slot being read
- res_valid  out  1  `phase_inc` currently at the stage output belongs to {res_bank, res_op}
- res_bank  out  BANK_NUM_WIDTH  tag of result
- res_op  out  OP_NUM_WIDTH  tag of result
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse coincident with last `res_valid` of a frame
- overrun  out  1  sticky: `sample_clk_en` seen while busy
- overrun_clr  in  1  clears `overrun`

Behaviour:
- Reset (reset_n=0 at edge): state IDLE; all outputs 0; slot counters 0; tag delay line cleared (all valid bits 0).
- Reset mid-frame: remaining slots abandoned; no further `res_valid` until the next frame.
- States: IDLE, ISSUE, DRAIN.
- IDLE: `busy`=0. `sample_clk_en`=1 at edge E0 -> ISSUE. Counters set to bank 0/op 0. `busy`=1 from E0.
- ISSUE: `rd_en`=1 every cycle with the current slot, cycles E0+1 .. E0+36.
  - op increments; at op==NUM_OPS-1 it wraps to 0 and bank increments.
  - After slot (NUM_BANKS-1, NUM_OPS-1) -> DRAIN, `rd_en`=0.
  - `rd_op` never exceeds 17; `rd_bank` never exceeds 1.
- Tag delay: {valid, bank, op} issued at cycle t appears on res_* at t+L, where L=RD_LATENCY+PIPE_LATENCY.
  - L=0 means res_* mirror rd_* combinationally.
- DRAIN: wait until the last tag emerges.
  - `frame_done`=1 in the same cycle as the last `res_valid` (E0+36+L).
  - Return to IDLE at the next edge; `busy` falls to 0 then.
  - If L=0, DRAIN is skipped and `frame_done` accompanies the final ISSUE cycle.
- Overrun: `sample_clk_en` while state≠IDLE, including the `frame_done` cycle, is ignored.
  - The current frame continues unaffected; `overrun` sets at the next edge.
- `overrun_clr` clears `overrun`; a simultaneous set wins (`overrun` stays 1).
- `res_valid` is exactly 36 cycles high per frame, contiguous; no gaps, no duplicates.
- Frame length 36+L ≤ 44 cycles; the clock/sample ratio guarantees ≥ 44 cycles between strobes in normal operation.

Optional Feature:
- Macro PHASE_SCHED_OVERRUN_CNT_EN.
- Defined:
  - Adds output `overrun_cnt` (8 bits).
  - Saturating count of ignored `sample_clk_en` strobes; holds at 255.
  - Reset to 0 by reset_n; cleared by `overrun_clr`. Simultaneous clear and new overrun -> count = 1.
- Undefined: port absent; only the sticky `overrun` flag exists. All other behaviour is identical.

Decomposition:
- Shared package: BANK_NUM_WIDTH, OP_NUM_WIDTH, NUM_BANKS, NUM_OPS constants and a packed slot typedef {bank, op}.
- Also in the package: a state enum typedef for IDLE/ISSUE/DRAIN.
- One natural sub-module, `slot_tag_delay`: parameterized-depth shift register of {valid, slot}. Depth 0 is pass-through; cleared by reset_n.
- The FSM and counters stay in the top module.

Test Plan:
- Default params, pulse `sample_clk_en` at E0:
  - `rd_en` high cycles E0+1..E0+36, slots (0,0)..(0,17),(1,0)..(1,17).
  - `res_valid` high E0+3..E0+38, same slot order.
  - `frame_done` only at E0+38; `busy` 0 at E0+39.
- Second `sample_clk_en` at E0+20, and another at E0+38:
  - Slot sequence unchanged; `overrun`=1.
  - With PHASE_SCHED_OVERRUN_CNT_EN: `overrun_cnt`=2.
  - `overrun_clr` together with a new overrun leaves `overrun`=1 and `overrun_cnt`=1.
- reset_n=0 for one cycle at E0+10:
  - All outputs 0 next cycle; no `res_valid`/`frame_done` for that frame.
  - A new strobe afterwards restarts at slot (0,0).
- RD_LATENCY=0, PIPE_LATENCY=0:
  - `res_valid` equals `rd_en` every cycle.
  - `frame_done` at E0+36; IDLE at E0+37.
- RD_LATENCY=2, PIPE_LATENCY=3: first `res_valid` at E0+6 tagged (0,0); `frame_done` at E0+41.
- Back-to-back frames: strobes 44 cycles apart over 100 frames -> no overrun, 3600 `res_valid` pulses, 100 `frame_done` pulses.

Source files
------------

// File: rtl/phase_inc_scheduler_pkg.sv
// Shared constants, slot/tag payloads and FSM state type for the phase-increment slot scheduler.
package phase_inc_scheduler_pkg;

    localparam int unsigned NUM_BANKS      = 2;
    localparam int unsigned NUM_OPS        = 18;
    localparam int unsigned BANK_NUM_WIDTH = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int unsigned OP_NUM_WIDTH   = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
    localparam int unsigned OVR_CNT_WIDTH  = 8;

    // One operator slot address
    typedef struct packed {
        logic [BANK_NUM_WIDTH-1:0] bank;
        logic [OP_NUM_WIDTH-1:0]   op;
    } slot_t;

    // Slot tag travelling alongside the register read / phase-increment pipeline
    typedef struct packed {
        logic  valid;
        slot_t slot;
    } tag_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // True for the final slot of a frame
    function automatic logic is_last_slot(input slot_t s);
        return (s.bank == BANK_NUM_WIDTH'(NUM_BANKS - 1)) &&
               (s.op   == OP_NUM_WIDTH'(NUM_OPS - 1));
    endfunction

endpackage

// File: rtl/phase_inc_scheduler_if.sv
// Read-request and result-tag bundle between the scheduler and the phase datapath.
interface phase_inc_scheduler_if;
    import phase_inc_scheduler_pkg::*;

    logic                      rd_en;
    logic [BANK_NUM_WIDTH-1:0] rd_bank;
    logic [OP_NUM_WIDTH-1:0]   rd_op;
    logic                      res_valid;
    logic [BANK_NUM_WIDTH-1:0] res_bank;
    logic [OP_NUM_WIDTH-1:0]   res_op;
    logic                      frame_done;

    modport master (
        output rd_en, rd_bank, rd_op,
        output res_valid, res_bank, res_op, frame_done
    );

    modport slave (
        input rd_en, rd_bank, rd_op,
        input res_valid, res_bank, res_op, frame_done
    );

endinterface

// File: rtl/phase_inc_scheduler_slot_tag_delay.sv
// Fixed-depth delay line for {valid, slot} tags; depth 0 is a wire.
module phase_inc_scheduler_slot_tag_delay
    import phase_inc_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  tag_t i_tag,
    output tag_t o_tag
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = clk ^ reset_n;
            assign o_tag            = i_tag;
        end else begin : g_pipe
            tag_t r_pipe [DEPTH];

            // Shift tags one stage per cycle; reset drops every in-flight tag
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        r_pipe[i] <= '0;
                    end
                end else begin
                    r_pipe[0] <= i_tag;
                    for (int i = 1; i < int'(DEPTH); i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign o_tag = r_pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/phase_inc_scheduler.sv
// Per-sample slot sequencer: walks bank 0 ops 0..17 then bank 1 ops 0..17 on each
// sample strobe, issues register reads and tags results leaving the phase-increment stage.
// Optional PHASE_SCHED_OVERRUN_CNT_EN adds a saturating count of ignored strobes.
module phase_inc_scheduler
    import phase_inc_scheduler_pkg::*;
#(
    parameter int unsigned RD_LATENCY   = 1,
    parameter int unsigned PIPE_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_sample_clk_en,
    input  logic                     i_overrun_clr,
    phase_inc_scheduler_if.master    bus,
    output logic                     o_busy,
    output logic                     o_overrun
`ifdef PHASE_SCHED_OVERRUN_CNT_EN
   ,output logic [OVR_CNT_WIDTH-1:0] o_overrun_cnt
`endif
);

    localparam int unsigned TAG_DELAY = RD_LATENCY + PIPE_LATENCY;

    state_t r_state;
    state_t w_state_nxt;
    slot_t  r_cnt;
    slot_t  w_cnt_nxt;
    logic   r_rd_en;
    logic   w_rd_en_nxt;
    slot_t  r_rd_slot;
    slot_t  w_rd_slot_nxt;
    logic   r_busy;
    logic   r_overrun;
    tag_t   w_tag_in;
    tag_t   w_tag_out;
    logic   w_frame_done;
    logic   w_overrun_set;

    // Tag each read with its slot so it emerges alongside the matching phase_inc
    assign w_tag_in = '{valid: r_rd_en, slot: r_rd_slot};

    phase_inc_scheduler_slot_tag_delay #(
        .DEPTH (TAG_DELAY)
    ) u_slot_tag_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .i_tag   (w_tag_in),
        .o_tag   (w_tag_out)
    );

    assign w_frame_done  = w_tag_out.valid && is_last_slot(w_tag_out.slot);
    assign w_overrun_set = i_sample_clk_en && (r_state != IDLE);

    // State, slot counter and registered read request
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_rd_en   <= 1'b0;
            r_rd_slot <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rd_en   <= w_rd_en_nxt;
            r_rd_slot <= w_rd_slot_nxt;
            r_busy    <= (w_state_nxt != IDLE);
        end
    end

    // Next-state, slot advance and read issue
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_rd_en_nxt   = 1'b0;
        w_rd_slot_nxt = '0;
        case (r_state)
            IDLE: begin
                if (i_sample_clk_en) begin
                    w_state_nxt = ISSUE;
                    w_cnt_nxt   = '0;
                end
            end
            ISSUE: begin
                w_rd_en_nxt   = 1'b1;
                w_rd_slot_nxt = r_cnt;
                if (is_last_slot(r_cnt)) begin
                    w_state_nxt = DRAIN;
                    w_cnt_nxt   = '0;
                end else if (r_cnt.op == OP_NUM_WIDTH'(NUM_OPS - 1)) begin
                    w_cnt_nxt.op   = '0;
                    w_cnt_nxt.bank = r_cnt.bank + BANK_NUM_WIDTH'(1);
                end else begin
                    w_cnt_nxt.op = r_cnt.op + OP_NUM_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (w_frame_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Sticky overrun flag; a new overrun wins over a clear in the same cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_overrun <= 1'b0;
        end else if (w_overrun_set) begin
            r_overrun <= 1'b1;
        end else if (i_overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

`ifdef PHASE_SCHED_OVERRUN_CNT_EN
    logic [OVR_CNT_WIDTH-1:0] r_overrun_cnt;

    // Saturating count of ignored strobes; clear plus new overrun leaves one
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_overrun_cnt <= '0;
        end else if (i_overrun_clr) begin
            r_overrun_cnt <= w_overrun_set ? OVR_CNT_WIDTH'(1) : '0;
        end else if (w_overrun_set && (r_overrun_cnt != {OVR_CNT_WIDTH{1'b1}})) begin
            r_overrun_cnt <= r_overrun_cnt + OVR_CNT_WIDTH'(1);
        end
    end

    assign o_overrun_cnt = r_overrun_cnt;
`endif

    assign bus.rd_en      = r_rd_en;
    assign bus.rd_bank    = r_rd_slot.bank;
    assign bus.rd_op      = r_rd_slot.op;
    assign bus.res_valid  = w_tag_out.valid;
    assign bus.res_bank   = w_tag_out.slot.bank;
    assign bus.res_op     = w_tag_out.slot.op;
    assign bus.frame_done = w_frame_done;
    assign o_busy         = r_busy;
    assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_phase_inc_scheduler.sv
// Bench for phase_inc_scheduler: three instances with tag latencies 2 (default), 0 and 5.
module tb_phase_inc_scheduler;
    import phase_inc_scheduler_pkg::*;

    localparam int NDUT = 3;
    localparam int NVEC = 11;

    typedef struct packed {
        logic                      rd_en;
        logic [BANK_NUM_WIDTH-1:0] rd_bank;
        logic [OP_NUM_WIDTH-1:0]   rd_op;
        logic                      res_valid;
        logic [BANK_NUM_WIDTH-1:0] res_bank;
        logic [OP_NUM_WIDTH-1:0]   res_op;
        logic                      done;
        logic                      busy;
        logic                      ovr;
    } obs_t;

    typedef struct {
        int k;
        int rd_en;
        int rd_bank;
        int rd_op;
        int res_valid;
        int res_bank;
        int res_op;
        int done;
        int busy;
    } vec_t;

    logic clk;
    logic reset_n;
    logic overrun_clr;
    logic strobe [NDUT];
    obs_t obs [NDUT];
`ifdef PHASE_SCHED_OVERRUN_CNT_EN
    logic [OVR_CNT_WIDTH-1:0] ovr_cnt [NDUT];
`endif
    int   lat [NDUT];
    vec_t vec [NVEC];
    int   n_checks;
    int   n_errors;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned RDL = (g == 0) ? 1 : (g == 1) ? 0 : 2;
        localparam int unsigned PPL = (g == 0) ? 1 : (g == 1) ? 0 : 3;
        phase_inc_scheduler_if u_if ();
        logic w_busy;
        logic w_ovr;

        phase_inc_scheduler #(
            .RD_LATENCY   (RDL),
            .PIPE_LATENCY (PPL)
        ) u_dut (
            .clk             (clk),
            .reset_n         (reset_n),
            .i_sample_clk_en (strobe[g]),
            .i_overrun_clr   (overrun_clr),
            .bus             (u_if),
            .o_busy          (w_busy),
            .o_overrun       (w_ovr)
`ifdef PHASE_SCHED_OVERRUN_CNT_EN
           ,.o_overrun_cnt   (ovr_cnt[g])
`endif
        );

        assign obs[g] = '{rd_en: u_if.rd_en, rd_bank: u_if.rd_bank, rd_op: u_if.rd_op,
                          res_valid: u_if.res_valid, res_bank: u_if.res_bank, res_op: u_if.res_op,
                          done: u_if.frame_done, busy: w_busy, ovr: w_ovr};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs k cycles after the starting edge, for tag latency l
    task automatic check_model(input int d, input int k);
        int  l;
        int  s;
        int  r;
        bit  e_rd;
        bit  e_res;
        l     = lat[d];
        s     = k - 1;
        r     = k - 1 - l;
        e_rd  = (k >= 1) && (k <= 36);
        e_res = (k >= 1 + l) && (k <= 36 + l);
        chk($sformatf("d%0d k%0d rd_en", d, k), 32'(obs[d].rd_en), 32'(e_rd));
        if (e_rd) begin
            chk($sformatf("d%0d k%0d rd_bank", d, k), 32'(obs[d].rd_bank), s / 18);
            chk($sformatf("d%0d k%0d rd_op", d, k), 32'(obs[d].rd_op), s % 18);
        end
        chk($sformatf("d%0d k%0d res_valid", d, k), 32'(obs[d].res_valid), 32'(e_res));
        if (e_res) begin
            chk($sformatf("d%0d k%0d res_bank", d, k), 32'(obs[d].res_bank), r / 18);
            chk($sformatf("d%0d k%0d res_op", d, k), 32'(obs[d].res_op), r % 18);
        end
        chk($sformatf("d%0d k%0d frame_done", d, k), 32'(obs[d].done), 32'(k == 36 + l));
        chk($sformatf("d%0d k%0d busy", d, k), 32'(obs[d].busy), 32'(k <= 36 + l));
    endtask

    task automatic check_vec(input int ti);
        chk($sformatf("vec%0d rd_en", ti), 32'(obs[0].rd_en), vec[ti].rd_en);
        if (vec[ti].rd_en != 0) begin
            chk($sformatf("vec%0d rd_bank", ti), 32'(obs[0].rd_bank), vec[ti].rd_bank);
            chk($sformatf("vec%0d rd_op", ti), 32'(obs[0].rd_op), vec[ti].rd_op);
        end
        chk($sformatf("vec%0d res_valid", ti), 32'(obs[0].res_valid), vec[ti].res_valid);
        if (vec[ti].res_valid != 0) begin
            chk($sformatf("vec%0d res_bank", ti), 32'(obs[0].res_bank), vec[ti].res_bank);
            chk($sformatf("vec%0d res_op", ti), 32'(obs[0].res_op), vec[ti].res_op);
        end
        chk($sformatf("vec%0d frame_done", ti), 32'(obs[0].done), vec[ti].done);
        chk($sformatf("vec%0d busy", ti), 32'(obs[0].busy), vec[ti].busy);
    endtask

    task automatic check_all_zero(input string tag);
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("%s d%0d outputs", tag, d), 32'(obs[d]), 0);
`ifdef PHASE_SCHED_OVERRUN_CNT_EN
            chk($sformatf("%s d%0d overrun_cnt", tag, d), 32'(ovr_cnt[d]), 0);
`endif
        end
    endtask

    task automatic check_overrun(input string tag, input int e_flag, input int e_cnt);
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("%s d%0d overrun", tag, d), 32'(obs[d].ovr), e_flag);
`ifdef PHASE_SCHED_OVERRUN_CNT_EN
            chk($sformatf("%s d%0d overrun_cnt", tag, d), 32'(ovr_cnt[d]), e_cnt);
`else
            if (e_cnt < 0) $display("negative count request %0d", e_cnt);
`endif
        end
    endtask

    // One 44-cycle frame with optional extra strobes at k=20 and in the frame_done cycle
    task automatic run_frame(input bit use_tbl, input bit s20, input bit sdone, input bit c20);
        int ti;
        ti = 0;
        for (int k = 0; k < 44; k++) begin
            for (int d = 0; d < NDUT; d++) begin
                strobe[d] = (k == 0) || (s20 && (k == 20)) || (sdone && (k == 37 + lat[d]));
            end
            overrun_clr = c20 && (k == 20);
            step();
            for (int d = 0; d < NDUT; d++) strobe[d] = 1'b0;
            overrun_clr = 1'b0;
            for (int d = 0; d < NDUT; d++) check_model(d, k);
            if (use_tbl && (ti < NVEC) && (vec[ti].k == k)) begin
                check_vec(ti);
                ti++;
            end
        end
    endtask

    initial begin
        int n_res [NDUT];
        int n_done [NDUT];
        int n_ovr [NDUT];

        // Default instance (latency 2): {k, rd_en, rd_bank, rd_op, res_valid, res_bank, res_op, done, busy}
        vec[0]  = '{0,  0, 0, 0,  0, 0, 0,  0, 1};
        vec[1]  = '{1,  1, 0, 0,  0, 0, 0,  0, 1};
        vec[2]  = '{2,  1, 0, 1,  0, 0, 0,  0, 1};
        vec[3]  = '{3,  1, 0, 2,  1, 0, 0,  0, 1};
        vec[4]  = '{18, 1, 0, 17, 1, 0, 15, 0, 1};
        vec[5]  = '{19, 1, 1, 0,  1, 0, 16, 0, 1};
        vec[6]  = '{21, 1, 1, 2,  1, 1, 0,  0, 1};
        vec[7]  = '{36, 1, 1, 17, 1, 1, 15, 0, 1};
        vec[8]  = '{37, 0, 0, 0,  1, 1, 16, 0, 1};
        vec[9]  = '{38, 0, 0, 0,  1, 1, 17, 1, 1};
        vec[10] = '{39, 0, 0, 0,  0, 0, 0,  0, 0};
        lat = '{2, 0, 5};
        n_checks = 0;
        n_errors = 0;

        reset_n     = 1'b0;
        overrun_clr = 1'b0;
        for (int d = 0; d < NDUT; d++) strobe[d] = 1'b0;
        step();
        step();
        check_all_zero("reset");
        reset_n = 1'b1;
        step();

        // Clean frame
        run_frame(1'b1, 1'b0, 1'b0, 1'b0);
        check_overrun("clean", 0, 0);

        // Strobes mid-frame and in the frame_done cycle are ignored but flagged
        run_frame(1'b0, 1'b1, 1'b1, 1'b0);
        check_overrun("ovr2", 1, 2);

        // Clear coincident with a new overrun
        run_frame(1'b0, 1'b1, 1'b0, 1'b1);
        check_overrun("clr_set", 1, 1);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        check_overrun("clr", 0, 0);

        // Reset in the middle of a frame abandons it
        for (int d = 0; d < NDUT; d++) strobe[d] = 1'b1;
        step();
        for (int d = 0; d < NDUT; d++) strobe[d] = 1'b0;
        for (int k = 1; k < 10; k++) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check_all_zero("midreset");
        for (int d = 0; d < NDUT; d++) begin
            n_res[d]  = 0;
            n_done[d] = 0;
        end
        for (int c = 0; c < 50; c++) begin
            step();
            for (int d = 0; d < NDUT; d++) begin
                n_res[d]  += int'(obs[d].res_valid) + int'(obs[d].rd_en);
                n_done[d] += int'(obs[d].done);
            end
        end
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("after reset d%0d valid pulses", d), n_res[d], 0);
            chk($sformatf("after reset d%0d frame_done pulses", d), n_done[d], 0);
        end

        // Next frame restarts from slot (0,0)
        run_frame(1'b1, 1'b0, 1'b0, 1'b0);

        // 100 back-to-back frames at the minimum strobe spacing
        for (int d = 0; d < NDUT; d++) begin
            n_res[d]  = 0;
            n_done[d] = 0;
            n_ovr[d]  = 0;
        end
        for (int f = 0; f < 100; f++) begin
            for (int k = 0; k < 44; k++) begin
                for (int d = 0; d < NDUT; d++) strobe[d] = (k == 0);
                step();
                for (int d = 0; d < NDUT; d++) begin
                    strobe[d]  = 1'b0;
                    n_res[d]  += int'(obs[d].res_valid);
                    n_done[d] += int'(obs[d].done);
                    n_ovr[d]  += int'(obs[d].ovr);
                end
            end
        end
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("b2b d%0d res_valid pulses", d), n_res[d], 3600);
            chk($sformatf("b2b d%0d frame_done pulses", d), n_done[d], 100);
            chk($sformatf("b2b d%0d overrun cycles", d), n_ovr[d], 0);
        end
        check_overrun("b2b", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
